div_frac_nr_pip: RTL and testbench

// - Pipelined non-restoring unsigned fractional divider for the WFQ datapath (finish-time / weight ratios).
// - Computes Q = floor(D * 2^QW / B) for D < B, giving a QW-bit fraction < 1.
// - Successor to the fixed 16-bit free-running divider. Adds:
//   - parametrised operand and quotient widths;
//   - valid/ready flow control with stall, plus a tag passthrough;
//   - divide-by-zero and overflow flags with saturation;
//   - synchronous reset.

---
 rtl/wfq_div_pkg.sv | 19 +
 rtl/div_frac_nr_pip_if.sv | 34 +++
 rtl/div_nr_stage.sv | 87 ++++++++
 rtl/div_frac_nr_pip.sv | 132 +++++++++++++
 tb/tb_div_frac_nr_pip.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/wfq_div_pkg.sv
// Shared constants and helpers for the WFQ fractional divider.
package wfq_div_pkg;

  localparam int unsigned DefN    = 16;
  localparam int unsigned DefQW   = 16;
  localparam int unsigned DefTagW = 8;

  // Widest quotient the saturation constant can cover.
  localparam int unsigned MaxQW = 64;

  // Error results are forced to all-ones; slice to the quotient width.
  localparam logic [MaxQW-1:0] SatOnes = '1;

  // Partial remainder width: one bit for sign, one for |R| < 2B.
  function automatic int unsigned rw(input int unsigned n);
    return n + 2;
  endfunction

endpackage

// File: rtl/div_frac_nr_pip_if.sv
// Operand/result handshake bundle for the pipelined fractional divider.
interface div_frac_nr_pip_if
  import wfq_div_pkg::*;
#(
  parameter int unsigned N    = DefN,
  parameter int unsigned QW   = DefQW,
  parameter int unsigned TAGW = DefTagW
) ();

  logic            in_valid;
  logic            in_ready;
  logic [N-1:0]    dividend;
  logic [N-1:0]    divisor;
  logic [TAGW-1:0] in_tag;
  logic            out_valid;
  logic            out_ready;
  logic [QW-1:0]   quotient;
  logic [TAGW-1:0] out_tag;
  logic            div_zero;
  logic            ovf;

  // Producer/consumer side (drives operands, accepts results).
  modport master (
    output in_valid, dividend, divisor, in_tag, out_ready,
    input  in_ready, out_valid, quotient, out_tag, div_zero, ovf
  );

  // Divider side.
  modport slave (
    input  in_valid, dividend, divisor, in_tag, out_ready,
    output in_ready, out_valid, quotient, out_tag, div_zero, ovf
  );

endinterface

// File: rtl/div_nr_stage.sv
// One non-restoring iteration slice: emits the quotient bit from the sign of
// the incoming remainder and registers the next remainder 2R -/+ B.
module div_nr_stage
  import wfq_div_pkg::*;
#(
  parameter int unsigned N    = DefN,
  parameter int unsigned QW   = DefQW,
  parameter int unsigned TAGW = DefTagW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_advance,
  input  logic             i_valid,
  input  logic [rw(N)-1:0] i_rem,
  input  logic [N-1:0]     i_div,
  input  logic [QW-1:0]    i_q,
  input  logic [TAGW-1:0]  i_tag,
  input  logic             i_dz,
  input  logic             i_ov,
  output logic             o_valid,
  output logic [rw(N)-1:0] o_rem,
  output logic [N-1:0]     o_div,
  output logic [QW-1:0]    o_q,
  output logic [TAGW-1:0]  o_tag,
  output logic             o_dz,
  output logic             o_ov
);

  localparam int unsigned RW = rw(N);

  logic            r_valid;
  logic [RW-1:0]   r_rem;
  logic [N-1:0]    r_div;
  logic [QW-1:0]   r_q;
  logic [TAGW-1:0] r_tag;
  logic            r_dz;
  logic            r_ov;

  logic            w_sign;
  logic [RW-1:0]   w_rem_dbl;
  logic [RW-1:0]   w_operand;
  logic [RW-1:0]   w_rem_nxt;
  logic [QW-1:0]   w_q_nxt;
  logic            w_unused_q_msb;

  // Single adder: add B when R < 0, otherwise add ~B + 1 (subtract B).
  always_comb begin
    w_sign    = i_rem[RW-1];
    w_rem_dbl = {i_rem[RW-2:0], 1'b0};
    w_operand = w_sign ? {2'b00, i_div} : ~{2'b00, i_div};
    w_rem_nxt = w_rem_dbl + w_operand + {{(RW-1){1'b0}}, ~w_sign};
    w_q_nxt   = {i_q[QW-2:0], ~w_sign};
  end

  // The oldest bit shifted out is the integer bit, known zero for valid results.
  assign w_unused_q_msb = i_q[QW-1];

  // Slice register; holds on a global stall, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_rem   <= '0;
      r_div   <= '0;
      r_q     <= '0;
      r_tag   <= '0;
      r_dz    <= 1'b0;
      r_ov    <= 1'b0;
    end else if (i_advance) begin
      r_valid <= i_valid;
      r_rem   <= w_rem_nxt;
      r_div   <= i_div;
      r_q     <= w_q_nxt;
      r_tag   <= i_tag;
      r_dz    <= i_dz;
      r_ov    <= i_ov;
    end
  end

  assign o_valid = r_valid;
  assign o_rem   = r_rem;
  assign o_div   = r_div;
  assign o_q     = r_q;
  assign o_tag   = r_tag;
  assign o_dz    = r_dz;
  assign o_ov    = r_ov;

endmodule

// File: rtl/div_frac_nr_pip.sv
// Pipelined non-restoring unsigned fractional divider: Q = floor(D * 2^QW / B)
// for D < B, with global-stall valid/ready flow control and tag passthrough.
module div_frac_nr_pip
  import wfq_div_pkg::*;
#(
  parameter int unsigned N    = DefN,
  parameter int unsigned QW   = DefQW,
  parameter int unsigned TAGW = DefTagW
) (
  input logic              clk,
  input logic              rst,
  div_frac_nr_pip_if.slave bus
);

  localparam int unsigned RW = rw(N);

  logic w_advance;
  logic w_out_valid;

  // Accept-stage registers.
  logic            r_s0_valid;
  logic [RW-1:0]   r_s0_rem;
  logic [N-1:0]    r_s0_div;
  logic [TAGW-1:0] r_s0_tag;
  logic            r_s0_dz;
  logic            r_s0_ov;

  logic [RW-1:0]   w_s0_rem;
  logic            w_s0_dz;
  logic            w_s0_ov;

  // Pipeline chain; index 0 is the accept stage, index k the k-th iteration.
  logic            w_valid [QW+1];
  logic [RW-1:0]   w_rem   [QW+1];
  logic [N-1:0]    w_div   [QW+1];
  logic [QW-1:0]   w_q     [QW+1];
  logic [TAGW-1:0] w_tag   [QW+1];
  logic            w_dz    [QW+1];
  logic            w_ov    [QW+1];

  logic [QW-1:0]   w_quot;
  logic            w_err;
  logic            w_unused_tail;

  // Accept-stage classification and initial remainder D - B.
  always_comb begin
    w_s0_dz  = (bus.divisor == '0);
    w_s0_ov  = ~w_s0_dz & (bus.dividend >= bus.divisor);
    w_s0_rem = {2'b00, bus.dividend} - {2'b00, bus.divisor};
  end

  // Accept stage; in_ready equals advance, so a transfer is in_valid & advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s0_valid <= 1'b0;
      r_s0_rem   <= '0;
      r_s0_div   <= '0;
      r_s0_tag   <= '0;
      r_s0_dz    <= 1'b0;
      r_s0_ov    <= 1'b0;
    end else if (w_advance) begin
      r_s0_valid <= bus.in_valid;
      r_s0_rem   <= w_s0_rem;
      r_s0_div   <= bus.divisor;
      r_s0_tag   <= bus.in_tag;
      r_s0_dz    <= w_s0_dz;
      r_s0_ov    <= w_s0_ov;
    end
  end

  assign w_valid[0] = r_s0_valid;
  assign w_rem[0]   = r_s0_rem;
  assign w_div[0]   = r_s0_div;
  assign w_q[0]     = '0;
  assign w_tag[0]   = r_s0_tag;
  assign w_dz[0]    = r_s0_dz;
  assign w_ov[0]    = r_s0_ov;

  for (genvar k = 1; k <= QW; k++) begin : g_stage
    div_nr_stage #(
      .N    (N),
      .QW   (QW),
      .TAGW (TAGW)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .i_advance (w_advance),
      .i_valid   (w_valid[k-1]),
      .i_rem     (w_rem[k-1]),
      .i_div     (w_div[k-1]),
      .i_q       (w_q[k-1]),
      .i_tag     (w_tag[k-1]),
      .i_dz      (w_dz[k-1]),
      .i_ov      (w_ov[k-1]),
      .o_valid   (w_valid[k]),
      .o_rem     (w_rem[k]),
      .o_div     (w_div[k]),
      .o_q       (w_q[k]),
      .o_tag     (w_tag[k]),
      .o_dz      (w_dz[k]),
      .o_ov      (w_ov[k])
    );
  end

  // Global stall: everything moves unless a result is waiting on the consumer.
  assign w_out_valid  = w_valid[QW];
  assign w_advance    = ~w_out_valid | bus.out_ready;
  assign bus.in_ready = w_advance;
  assign bus.out_valid = w_out_valid;

  // Output stage: final sign test of R[QW] supplies the LSB; errors saturate.
  always_comb begin
    w_quot = '0;
    w_err  = w_dz[QW] | w_ov[QW];
    if (w_out_valid) begin
      if (w_err) begin
        w_quot = SatOnes[QW-1:0];
      end else begin
        w_quot = {w_q[QW][QW-2:0], ~w_rem[QW][RW-1]};
      end
    end
  end

  assign bus.quotient = w_quot;
  assign bus.out_tag  = w_tag[QW];
  assign bus.div_zero = w_out_valid & w_dz[QW];
  assign bus.ovf      = w_out_valid & w_ov[QW];

  // Only the remainder sign matters at the tail; the integer bit is dropped.
  assign w_unused_tail = ^{w_div[QW], w_rem[QW][RW-2:0], w_q[QW][QW-1]};

endmodule

// File: tb/tb_div_frac_nr_pip.sv
// Self-checking bench for div_frac_nr_pip: directed cases, streaming,
// backpressure, mid-stream reset, and two alternate widths.
module tb_div_frac_nr_pip;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  div_frac_nr_pip_if #(.N(16), .QW(16), .TAGW(8)) if_a ();
  div_frac_nr_pip_if #(.N(8),  .QW(12), .TAGW(8)) if_b ();
  div_frac_nr_pip_if #(.N(32), .QW(24), .TAGW(8)) if_c ();

  div_frac_nr_pip #(.N(16), .QW(16), .TAGW(8)) u_a (.clk(clk), .rst(rst), .bus(if_a));
  div_frac_nr_pip #(.N(8),  .QW(12), .TAGW(8)) u_b (.clk(clk), .rst(rst), .bus(if_b));
  div_frac_nr_pip #(.N(32), .QW(24), .TAGW(8)) u_c (.clk(clk), .rst(rst), .bus(if_c));

  typedef struct {
    logic [63:0] q;
    logic [7:0]  tag;
    logic        dz;
    logic        ov;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];

  int checks = 0;
  int errors = 0;
  int n_in_a = 0;
  int n_out_a = 0;
  int run = 0;
  int max_run = 0;
  bit stall_prev = 1'b0;
  logic [15:0] held_q;
  logic [7:0]  held_tag;
  logic        held_dz;
  logic        held_ov;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division of the scaled dividend.
  function automatic exp_t model(input logic [63:0] d, input logic [63:0] b, input int qw,
                                 input logic [7:0] t);
    exp_t e;
    e.tag = t;
    e.dz  = (b == 0);
    e.ov  = (b != 0) && (d >= b);
    if (e.dz || e.ov) e.q = (64'd1 << qw) - 64'd1;
    else              e.q = (d << qw) / b;
    return e;
  endfunction

  task automatic rand_a(input bit allow_err, output logic [15:0] d, output logic [15:0] b);
    if (allow_err && $urandom_range(0, 7) == 0) begin
      d = 16'($urandom);
      b = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
    end else begin
      b = 16'($urandom_range(1, 65535));
      d = 16'($urandom_range(0, 32'(b) - 1));
    end
  endtask

  // One cycle on the 16/16 divider; entered and left at a negedge.
  task automatic step_a(input bit v, input logic [15:0] d, input logic [15:0] b,
                        input logic [7:0] t, input bit ordy, input bit use_lit,
                        input logic [15:0] lit);
    exp_t e;
    if_a.in_valid  = v;
    if_a.dividend  = d;
    if_a.divisor   = b;
    if_a.in_tag    = t;
    if_a.out_ready = ordy;
    #1;
    check("a_in_ready", 64'(if_a.in_ready), 64'(!if_a.out_valid || ordy));
    if (stall_prev) begin
      check("a_hold", 64'({if_a.quotient, if_a.out_tag, if_a.div_zero, if_a.ovf}),
            64'({held_q, held_tag, held_dz, held_ov}));
    end
    if (if_a.out_valid) begin
      run++;
      if (run > max_run) max_run = run;
      if (q_a.size() == 0) begin
        check("a_spurious_valid", 64'(if_a.out_valid), 64'd0);
      end else begin
        e = q_a[0];
        check("a_result", 64'({if_a.quotient, if_a.out_tag, if_a.div_zero, if_a.ovf}),
              64'({e.q[15:0], e.tag, e.dz, e.ov}));
        if (ordy) begin
          void'(q_a.pop_front());
          n_out_a++;
        end
      end
    end else begin
      run = 0;
    end
    if (v && if_a.in_ready) begin
      e = model(64'(d), 64'(b), 16, t);
      if (use_lit) e.q = 64'(lit);
      q_a.push_back(e);
      n_in_a++;
    end
    stall_prev = if_a.out_valid && !ordy;
    held_q     = if_a.quotient;
    held_tag   = if_a.out_tag;
    held_dz    = if_a.div_zero;
    held_ov    = if_a.ovf;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain_a();
    for (int k = 0; k < 300 && q_a.size() != 0; k++) step_a(1'b0, 0, 0, 0, 1'b1, 1'b0, 0);
    check("a_drain_empty", 64'(q_a.size()), 64'd0);
  endtask

  task automatic latency_a(input logic [15:0] d, input logic [15:0] b, input logic [15:0] lit);
    int cnt;
    step_a(1'b1, d, b, 8'hA5, 1'b1, 1'b1, lit);
    cnt = 1;
    while (!if_a.out_valid && cnt < 40) begin
      step_a(1'b0, 0, 0, 0, 1'b1, 1'b0, 0);
      cnt++;
    end
    check("a_latency", 64'(cnt), 64'd17);
    drain_a();
  endtask

  // One cycle on the 8/12 and 32/24 dividers, consumers always ready.
  task automatic step_bc(input bit vb, input logic [7:0] db, input logic [7:0] bb,
                         input bit vc, input logic [31:0] dc, input logic [31:0] bc,
                         input logic [7:0] t, input bit use_lit, input logic [11:0] lit);
    exp_t e;
    if_b.in_valid = vb; if_b.dividend = db; if_b.divisor = bb; if_b.in_tag = t;
    if_c.in_valid = vc; if_c.dividend = dc; if_c.divisor = bc; if_c.in_tag = t;
    if_b.out_ready = 1'b1;
    if_c.out_ready = 1'b1;
    #1;
    if (if_b.out_valid) begin
      if (q_b.size() == 0) check("b_spurious_valid", 64'(if_b.out_valid), 64'd0);
      else begin
        e = q_b.pop_front();
        check("b_result", 64'({if_b.quotient, if_b.out_tag, if_b.div_zero, if_b.ovf}),
              64'({e.q[11:0], e.tag, e.dz, e.ov}));
      end
    end
    if (if_c.out_valid) begin
      if (q_c.size() == 0) check("c_spurious_valid", 64'(if_c.out_valid), 64'd0);
      else begin
        e = q_c.pop_front();
        check("c_result", 64'({if_c.quotient, if_c.out_tag, if_c.div_zero, if_c.ovf}),
              64'({e.q[23:0], e.tag, e.dz, e.ov}));
      end
    end
    if (vb && if_b.in_ready) begin
      e = model(64'(db), 64'(bb), 12, t);
      if (use_lit) e.q = 64'(lit);
      q_b.push_back(e);
    end
    if (vc && if_c.in_ready) q_c.push_back(model(64'(dc), 64'(bc), 24, t));
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [15:0] dd [7] = '{16'd1, 16'd1, 16'd2, 16'd0, 16'd5, 16'd9, 16'd10};
  logic [15:0] db [7] = '{16'd2, 16'd3, 16'd3, 16'd7, 16'd0, 16'd9, 16'd9};
  logic [15:0] dq [7] = '{16'h8000, 16'h5555, 16'hAAAA, 16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF};

  initial begin
    logic [15:0] d, b;
    logic [7:0]  d8, b8;
    logic [31:0] d32, b32;
    int in_base, out_base, cyc;

    if_a.in_valid = 1'b0; if_a.dividend = '0; if_a.divisor = '0; if_a.in_tag = '0;
    if_a.out_ready = 1'b0;
    if_b.in_valid = 1'b0; if_b.dividend = '0; if_b.divisor = '0; if_b.in_tag = '0;
    if_b.out_ready = 1'b0;
    if_c.in_valid = 1'b0; if_c.dividend = '0; if_c.divisor = '0; if_c.in_tag = '0;
    if_c.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;

    // Reset state, consumer not ready.
    check("rst_out_valid", 64'(if_a.out_valid), 64'd0);
    check("rst_outputs", 64'({if_a.quotient, if_a.out_tag, if_a.div_zero, if_a.ovf}), 64'd0);
    check("rst_in_ready", 64'(if_a.in_ready), 64'd1);
    check("rst_b_out_valid", 64'(if_b.out_valid), 64'd0);
    @(negedge clk);

    // Directed: first case also measures latency, the rest back to back.
    latency_a(dd[0], db[0], dq[0]);
    for (int i = 1; i < 7; i++) step_a(1'b1, dd[i], db[i], 8'(i), 1'b1, 1'b1, dq[i]);
    drain_a();

    // 100 back-to-back D<B ops with tags 0..99.
    max_run = 0;
    run = 0;
    for (int i = 0; i < 100; i++) begin
      rand_a(1'b0, d, b);
      step_a(1'b1, d, b, 8'(i), 1'b1, 1'b0, 0);
    end
    drain_a();
    check("a_b2b_run", 64'(max_run), 64'd100);

    // Random backpressure over 1000 accepted ops, some with error flags.
    in_base  = n_in_a;
    out_base = n_out_a;
    for (cyc = 0; cyc < 20000 && (n_in_a - in_base) < 1000; cyc++) begin
      rand_a(1'b1, d, b);
      step_a($urandom_range(0, 3) != 0, d, b, 8'(n_in_a - in_base),
             $urandom_range(0, 1) == 1, 1'b0, 0);
    end
    drain_a();
    check("bp_accepted", 64'(n_in_a - in_base), 64'd1000);
    check("bp_emitted", 64'(n_out_a - out_base), 64'd1000);

    // Reset with 10 ops in flight.
    for (int i = 0; i < 10; i++) begin
      rand_a(1'b0, d, b);
      step_a(1'b1, d, b, 8'(i), 1'b1, 1'b0, 0);
    end
    rst = 1'b1;
    step_a(1'b0, 0, 0, 0, 1'b1, 1'b0, 0);
    rst = 1'b0;
    #1;
    check("rst_mid_out_valid", 64'(if_a.out_valid), 64'd0);
    q_a.delete();
    stall_prev = 1'b0;
    for (int i = 0; i < 30; i++) step_a(1'b0, 0, 0, 0, 1'b1, 1'b0, 0);
    latency_a(16'd2, 16'd3, 16'hAAAA);

    // Alternate widths: 8/12 corner, then random regression on both.
    step_bc(1'b1, 8'hFE, 8'hFF, 1'b1, 32'd1, 32'd3, 8'd0, 1'b1, 12'hFEF);
    for (int i = 1; i <= 300; i++) begin
      b8  = 8'($urandom_range(1, 255));
      d8  = 8'($urandom_range(0, 32'(b8) - 1));
      b32 = $urandom_range(1, 32'hFFFF_FFFF);
      d32 = $urandom % b32;
      if (i % 37 == 0) b8 = 8'd0;
      if (i % 41 == 0) d32 = b32;
      step_bc(1'b1, d8, b8, 1'b1, d32, b32, 8'(i), 1'b0, 0);
    end
    for (int k = 0; k < 60 && (q_b.size() != 0 || q_c.size() != 0); k++) begin
      step_bc(1'b0, 0, 0, 1'b0, 0, 0, 0, 1'b0, 0);
    end
    check("b_drain_empty", 64'(q_b.size()), 64'd0);
    check("c_drain_empty", 64'(q_c.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
